cla_sub_serial: RTL and testbench
=================================

# cla_sub_serial

Multi-cycle two's-complement subtractor computing diff = a − b over NIBBLES·4 bits, one 4-bit carry-lookahead slice per clock, with a registered carry passed between slices. It is the subtract-side companion to the team's 4-bit lookahead adder slice, and reuses the same propagate/generate lookahead equations on inverted b. A start/busy/done handshake frames each operation. Final results are held stable until the next operation completes.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4·NIBBLES; legal values 1..8.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  W  minuend; sampled on the accepting edge only.
- b  in  W  subtrahend; sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when results update.
- diff  out  W  a − b mod 2^W (registered).
- borrow  out  1  1 when a < b unsigned (inverted final carry).
- ovf  out  1  signed overflow flag (see Configuration).

## Operation
- Two states: IDLE and RUN. State register and counter cnt use ceil(log2(NIBBLES)) bits, minimum 1.
- IDLE, start=1: latch a into a_r and ~b into nb_r; set c_r=1 (the +1 of two's complement); set cnt=0; go to RUN; set busy=1.
- RUN, each edge, for slice k=cnt:
  - p = a_r[k] ^ nb_r[k]; g = a_r[k] & nb_r[k].
  - c1 = g0 | p0·c.
  - c2 = g1 | p1g0 | p1p0c.
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c.
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c.
  - Sum bits p_i ^ c_i are written to work register nibble k. Set c_r=c4, cnt=cnt+1.
- Edge where cnt==NIBBLES−1:
  - diff ← full work value, including this slice.
  - borrow ← ~c4.
  - ovf ← c3 ^ c4 of the top slice.
  - done ← 1; busy ← 0; state → IDLE.
- Arithmetic is modulo 2^W. No saturation.
- diff, borrow and ovf hold until the next completing edge. They do not change during RUN.
- start while busy is ignored. Operand inputs are ignored outside the accepting edge.
- start high in the cycle done is high (state is IDLE) is accepted. done falls on that edge and busy rises.

## Timing
- Reset edge: state IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0; cnt=0, c_r=0, work=0.
- Accept edge E0. Slices are processed on E1..E_NIBBLES. done is high in the cycle after E_NIBBLES, exactly one cycle.
- Throughput: one result per NIBBLES+1 edges with back-to-back start.
- busy is high from after E0 through E_NIBBLES (NIBBLES cycles).
- rst mid-RUN: the operation is aborted, no done is issued, all outputs return to reset values on that edge.
- rst and start both high: rst wins.
- NIBBLES=1: E1 completes; done is high the following cycle.

## Configuration
- CLA_SUB_OVF_EN defined: ovf is computed and registered as described in Operation.
- CLA_SUB_OVF_EN undefined: ovf is tied to constant 0 and no overflow register is built. All other behaviour is identical.

## Test plan
All scenarios use NIBBLES=4.
- a=0x1234, b=0x0234, start at E0 -> done high in the cycle after E4; diff=0x1000, borrow=0, ovf=0.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0; ovf=1 with CLA_SUB_OVF_EN, ovf=0 without.
- a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1; ovf=1 with CLA_SUB_OVF_EN.
- Op1 0x0010−0x0001. At E2, start=1 with 0xAAAA−0x5555: ignored, op1 yields diff=0x000F at done. Then start=1 in the done cycle with 0xAAAA−0x5555: diff=0x5555, borrow=0, done 5 edges later.
- rst=1 at E2 of 0x1234−0x0234 -> no done pulse, all outputs 0. A fresh start then gives diff=0x1000 on schedule.

Source files
------------

// File: rtl/cla_sub_serial.sv
// rtl/cla_sub_serial.sv - multi-cycle subtractor, one 4-bit lookahead slice per clock
//
// Computes o_diff = i_a - i_b modulo 2^(4*NIBBLES). Each RUN cycle adds one nibble
// of a to ~b through 4-bit carry lookahead. The carry out of each slice is
// registered and feeds the next slice. The initial carry of 1 supplies the +1
// of two's complement.
//
// Optional feature macro: CLA_SUB_OVF_EN. When it is defined, the signed
// overflow flag is computed and registered. When it is undefined, o_ovf is
// tied to 0.
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst     synchronous active-high reset
//   i_start   request; sampled only in IDLE
//   i_a       minuend; sampled on the accepting edge
//   i_b       subtrahend; sampled on the accepting edge
//   o_busy    high while slices are being processed
//   o_done    one-cycle pulse when results update
//   o_diff    a - b mod 2^W (registered, held between operations)
//   o_borrow  1 when a < b unsigned
//   o_ovf     signed overflow (0 unless CLA_SUB_OVF_EN)

module cla_sub_serial #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES,
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_diff,
    output logic         o_borrow,
    output logic         o_ovf
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_c;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_nb;
    logic [W-1:0]  r_work;
    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_diff;
    logic          r_borrow;

    logic [3:0]    w_a_nib;
    logic [3:0]    w_nb_nib;
    logic [3:0]    w_p;
    logic [3:0]    w_g;
    logic [4:0]    w_c;
    logic [3:0]    w_sum;
    logic [W-1:0]  w_work_next;
    logic          w_last;

    // Current slice operands, selected by the slice counter.
    assign w_a_nib  = r_a[{r_cnt, 2'b00} +: 4];
    assign w_nb_nib = r_nb[{r_cnt, 2'b00} +: 4];

    assign w_p = w_a_nib ^ w_nb_nib;
    assign w_g = w_a_nib & w_nb_nib;

    // Flat lookahead: every carry comes straight from p/g and the slice carry-in.
    assign w_c[0] = r_c;
    assign w_c[1] = w_g[0] | (w_p[0] & r_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c);

    assign w_sum  = w_p ^ w_c[3:0];
    assign w_last = (r_cnt == CW'(NIBBLES - 1));

    always_comb begin
        w_work_next = r_work;
        w_work_next[{r_cnt, 2'b00} +: 4] = w_sum;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_a      <= '0;
            r_nb     <= '0;
            r_work   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_nb    <= ~i_b;
                        r_c     <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_work <= w_work_next;
                    r_c    <= w_c[4];
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_diff   <= w_work_next;
                        r_borrow <= ~w_c[4];
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CLA_SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the top bit differs from carry out of it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= w_c[3] ^ w_c[4];
        end
    end

    assign o_ovf = r_ovf;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_diff   = r_diff;
    assign o_borrow = r_borrow;

endmodule

// File: tb/tb_cla_sub_serial.sv
// tb/tb_cla_sub_serial.sv - randomized self-checking bench for cla_sub_serial
module tb_cla_sub_serial;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_diff;
    logic         exp_borrow;
    logic         exp_ovf;

    cla_sub_serial #(.NIBBLES(NIBBLES)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_a      (a_in),
        .i_b      (b_in),
        .o_busy   (busy),
        .o_done   (done),
        .o_diff   (diff),
        .o_borrow (borrow),
        .o_ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_diff   = a - b;
        exp_borrow = (a < b);
`ifdef CLA_SUB_OVF_EN
        exp_ovf    = (a[W-1] != b[W-1]) && (exp_diff[W-1] != a[W-1]);
`else
        exp_ovf    = 1'b0;
`endif
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts an operation at the current negedge and returns at the negedge
    // where done is high. Start and operands are scrambled while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        step();
        cyc = 0;
        while (!done && cyc < 20) begin
            check("busy_run", busy, 1);
            check("hold_diff", diff, exp_diff);
            check("hold_borrow", borrow, exp_borrow);
            check("hold_ovf", ovf, exp_ovf);
            start = 1'($urandom);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            step();
            cyc++;
        end
        start = 1'b0;
        model(a, b);
        check("latency", cyc, NIBBLES);
        check("done", done, 1);
        check("busy_done", busy, 0);
        check("diff", diff, exp_diff);
        check("borrow", borrow, exp_borrow);
        check("ovf", ovf, exp_ovf);
    endtask

    task automatic idle_after;
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        step();
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("idle_diff", diff, exp_diff);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        a_in       = '0;
        b_in       = '0;
        exp_diff   = '0;
        exp_borrow = 1'b0;
        exp_ovf    = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_ovf", ovf, 0);

        run_op(16'h1234, 16'h0234); idle_after();
        run_op(16'h0000, 16'h0001); idle_after();
        run_op(16'h8000, 16'h0001); idle_after();
        run_op(16'h7FFF, 16'hFFFF); idle_after();

        // Ignored start while busy, then back-to-back start in the done cycle.
        run_op(16'h0010, 16'h0001);
        run_op(16'hAAAA, 16'h5555);
        idle_after();

        // Reset in the middle of an operation.
        start = 1'b1;
        a_in  = 16'h1234;
        b_in  = 16'h0234;
        step();
        start = 1'b0;
        step();
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        exp_diff   = '0;
        exp_borrow = 1'b0;
        exp_ovf    = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        check("abort_ovf", ovf, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_done", done, 0);
        end
        run_op(16'h1234, 16'h0234); idle_after();

        // Random operations with random back-to-back or idle gaps.
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                idle_after();
            end
        end
        idle_after();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
